// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display path: glyph table, index types,
// FSM state encodings and a glyph encoder matching the decoder table.
package display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] anode_vec_t;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETTLE  = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_LOCKED  = 2'd3;

  typedef enum logic [1:0] {
    SLOT_BLANK   = 2'd0,
    SLOT_SELECT  = 2'd1,
    SLOT_COLLIDE = 2'd2
  } slot_kind_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the glyph table: active-low segments -> hex value.
// hit is low for any pattern that is not one of the sixteen hex glyphs.
module seg7_glyph_decode
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] value
);

  always_comb begin
    hit   = 1'b1;
    value = 4'h0;
    case (seg)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and rebuilds the four displayed digits,
// capturing each scan slot once it has been stable for STABLE_CYCLES samples.
module display_scan_decoder
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seg0,
  input  logic       seg1,
  input  logic       seg2,
  input  logic       seg3,
  input  logic       seg4,
  input  logic       seg5,
  input  logic       seg6,
  input  logic       dp,
  input  logic       an1,
  input  logic       an2,
  input  logic       an3,
  input  logic       an4,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dp_out,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic [3:0] glyph_err,
  output logic [1:0] fsm_state
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

  // Bus sample layout: {an4, an3, an2, an1, dp, g, f, e, d, c, b, a}
  logic [11:0] bus_in;
  logic [11:0] s_reg;
  logic [7:0]  stable_cnt;
  logic        changed;

  anode_vec_t  an_low;
  slot_kind_t  slot_kind;
  digit_idx_t  slot_idx;

  logic        dec_hit;
  logic [3:0]  dec_value;

  state_t      state;
  state_t      state_next;
  logic        load_cap;

  digit_idx_t  cap_idx;
  logic        cap_dp;
  logic        cap_hit;
  logic [3:0]  cap_value;

  logic [3:0]  dig_r [4];
  logic [3:0]  frame_bits;
  logic        frame_full;
  logic [3:0]  cap_onehot;
  logic        do_capture;

  assign bus_in = {an4, an3, an2, an1, dp, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  // A cleared stable count marks the first cycle of a new bus value.
  assign changed = (stable_cnt == 8'd0);
  assign an_low  = ~s_reg[11:8];

  always_comb begin
    slot_kind = SLOT_COLLIDE;
    slot_idx  = 2'd0;
    case (an_low)
      4'b0000: slot_kind = SLOT_BLANK;
      4'b0001: begin slot_kind = SLOT_SELECT; slot_idx = 2'd0; end
      4'b0010: begin slot_kind = SLOT_SELECT; slot_idx = 2'd1; end
      4'b0100: begin slot_kind = SLOT_SELECT; slot_idx = 2'd2; end
      4'b1000: begin slot_kind = SLOT_SELECT; slot_idx = 2'd3; end
      default: slot_kind = SLOT_COLLIDE;
    endcase
  end

  seg7_glyph_decode u_glyph (
    .seg   (s_reg[6:0]),
    .hit   (dec_hit),
    .value (dec_value)
  );

  always_comb begin
    state_next = state;
    load_cap   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slot_kind == SLOT_SELECT) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (changed) begin
          state_next = (slot_kind == SLOT_SELECT) ? ST_SETTLE : ST_IDLE;
        end else if (stable_cnt >= CNT_CAP) begin
          state_next = ST_CAPTURE;
          load_cap   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (changed) state_next = (slot_kind == SLOT_SELECT) ? ST_SETTLE : ST_IDLE;
        else         state_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (changed) state_next = (slot_kind == SLOT_SELECT) ? ST_SETTLE : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign do_capture = (state == ST_CAPTURE);
  assign cap_onehot = 4'b0001 << cap_idx;
  assign frame_full = (frame_bits == 4'hF);

  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg       <= '1;
      stable_cnt  <= 8'd0;
      state       <= ST_IDLE;
      cap_idx     <= 2'd0;
      cap_dp      <= 1'b0;
      cap_hit     <= 1'b0;
      cap_value   <= 4'h0;
      frame_bits  <= 4'h0;
      frame_done  <= 1'b0;
      digit_valid <= 4'h0;
      glyph_err   <= 4'h0;
      dp_out      <= 4'h0;
      for (int i = 0; i < 4; i++) dig_r[i] <= 4'h0;
    end else begin
      s_reg <= bus_in;
      if (bus_in != s_reg)          stable_cnt <= 8'd0;
      else if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 8'd1;

      state <= state_next;

      // Snapshot the slot here so a bus change during CAPTURE cannot corrupt it.
      if (load_cap) begin
        cap_idx   <= slot_idx;
        cap_dp    <= ~s_reg[7];
        cap_hit   <= dec_hit;
        cap_value <= dec_value;
      end

      frame_done <= frame_full;
      frame_bits <= (frame_full ? 4'h0 : frame_bits) | (do_capture ? cap_onehot : 4'h0);

      if (do_capture) begin
        digit_valid[cap_idx] <= 1'b1;
        dp_out[cap_idx]      <= cap_dp;
        if (cap_hit) dig_r[cap_idx]     <= cap_value;
        else         glyph_err[cap_idx] <= 1'b1;
      end
    end
  end

  assign dig0      = dig_r[0];
  assign dig1      = dig_r[1];
  assign dig2      = dig_r[2];
  assign dig3      = dig_r[3];
  assign fsm_state = state;

endmodule
